// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
//
// Purpose: groups the raw pushbutton inputs and the conditioned control
// outputs of button_conditioner into one bundle. Clock and reset are
// plain module ports and are not part of this interface.
//
// Signals:
//   btn_run    - raw asynchronous start/stop pushbutton, active-high
//   btn_clr    - raw asynchronous clear pushbutton, active-high
//   run_en     - run/stop level for the downstream counter enable
//   clr_pulse  - single-cycle clear request to the downstream counter
//   run_pulse  - single-cycle strobe on each accepted run press
//   btn_run_db - debounced run button level
//   btn_clr_db - debounced clear button level
//
// Modports:
//   master - the side that drives the buttons and consumes the outputs
//   slave  - the conditioner itself
// ---------------------------------------------------------------------------
interface button_conditioner_if;
  logic btn_run;
  logic btn_clr;
  logic run_en;
  logic clr_pulse;
  logic run_pulse;
  logic btn_run_db;
  logic btn_clr_db;

  modport master (
    output btn_run,
    output btn_clr,
    input  run_en,
    input  clr_pulse,
    input  run_pulse,
    input  btn_run_db,
    input  btn_clr_db
  );

  modport slave (
    input  btn_run,
    input  btn_clr,
    output run_en,
    output clr_pulse,
    output run_pulse,
    output btn_run_db,
    output btn_clr_db
  );
endinterface

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Purpose: conditions two raw pushbuttons (run and clear) for a stopwatch-
// style counter. Each button is synchronized (2 flops), debounced with its
// own counter, and tracked by a RELEASED/PRESSED/HELD state machine that
// emits exactly one pulse per press. The run pulse toggles run_en; the
// clear pulse forces run_en low and has priority over a same-cycle run
// pulse.
//
// Optional feature: define BUTTON_CONDITIONER_LONG_PRESS_EN to add a
// long-press clear. Holding the run button LONG_COUNT cycles past its run
// pulse issues one clr_pulse and drops run_en. Without the macro there is
// no hold counter and clr_pulse comes only from btn_clr.
//
// Parameters:
//   DEBOUNCE_COUNT - consecutive stable cycles to accept a level change
//   LONG_COUNT     - run-button hold length for a long press (macro only)
//
// Ports:
//   clk_in - system clock, all logic on its rising edge
//   reset  - asynchronous, active-high reset
//   btn_if - button_conditioner_if.slave (buttons in, conditioned out)
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_COUNT = 1_000_000,
  parameter int LONG_COUNT     = 200_000_000
) (
  input  logic                 clk_in,
  input  logic                 reset,
  button_conditioner_if.slave  btn_if
);

  localparam int DB_W    = $clog2(DEBOUNCE_COUNT) + 1;
  localparam int NUM_BTN = 2;
  localparam int RUN_IDX = 0;
  localparam int CLR_IDX = 1;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } btn_state_t;

  // Per-button views exported from the generate loop.
  logic [NUM_BTN-1:0] raw_in;
  logic [NUM_BTN-1:0] btn_db;
  logic [NUM_BTN-1:0] btn_rise;

  assign raw_in = {btn_if.btn_clr, btn_if.btn_run};

  // -------------------------------------------------------------------------
  // Per-button synchronizer, debouncer and press FSM
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic            sync1_q;
    logic            sync2_q;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;
    logic            db_q;
    logic            db_d;
    logic            db_prev_q;
    btn_state_t      state_q;
    btn_state_t      state_d;
    logic            rise_d;

    // Debounce: count consecutive cycles where the synchronized level
    // disagrees with the accepted level; any agreement restarts the count.
    // The level is accepted on the DEBOUNCE_COUNT-th disagreeing edge.
    always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (sync2_q != db_q) begin
        if (cnt_q == DB_W'(DEBOUNCE_COUNT - 1)) begin
          db_d  = sync2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        cnt_q     <= '0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
      end else begin
        sync1_q   <= raw_in[gi];
        sync2_q   <= sync1_q;
        cnt_q     <= cnt_d;
        db_q      <= db_d;
        // Delayed copy of the debounced level for the registered edge detect.
        db_prev_q <= db_q;
      end
    end

    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        state_q <= RELEASED;
      end else begin
        state_q <= state_d;
      end
    end

    // Only RELEASED can accept a rise, so a long hold never re-triggers;
    // rise_d is registered into the pulse flop, making the pulse cycle the
    // same cycle the FSM sits in PRESSED.
    always_comb begin
      state_d = state_q;
      rise_d  = 1'b0;
      case (state_q)
        RELEASED: begin
          if (db_q && !db_prev_q) begin
            state_d = PRESSED;
            rise_d  = 1'b1;
          end
        end
        PRESSED: begin
          state_d = HELD;
        end
        HELD: begin
          if (!db_q) begin
            state_d = RELEASED;
          end
        end
        default: begin
          state_d = RELEASED;
        end
      endcase
    end

    assign btn_db[gi]   = db_q;
    assign btn_rise[gi] = rise_d;
  end

  // -------------------------------------------------------------------------
  // Long-press clear (optional)
  // -------------------------------------------------------------------------
  logic long_fire;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_COUNT) + 1;

  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic              run_held;

  assign run_held = (g_btn[RUN_IDX].state_q == HELD);

  // HELD starts one cycle after the run_pulse cycle, so reaching
  // LONG_COUNT cycles after the pulse means firing when the count shows
  // LONG_COUNT-2 completed HELD cycles. The count then parks at
  // LONG_COUNT-1 so the clear fires only once per press.
  always_comb begin
    hold_cnt_d = '0;
    long_fire  = 1'b0;
    if (run_held) begin
      long_fire = (hold_cnt_q == HOLD_W'(LONG_COUNT - 2));
      if (hold_cnt_q == HOLD_W'(LONG_COUNT - 1)) begin
        hold_cnt_d = hold_cnt_q;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign long_fire = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Output pulses and run enable
  // -------------------------------------------------------------------------
  logic run_pulse_q;
  logic run_pulse_d;
  logic clr_pulse_q;
  logic clr_pulse_d;
  logic run_en_q;
  logic run_en_d;

  // run_en changes on the same edge that launches the pulses, so the new
  // level appears together with the pulse. Clear wins over a same-cycle run.
  always_comb begin
    run_pulse_d = btn_rise[RUN_IDX];
    clr_pulse_d = btn_rise[CLR_IDX] | long_fire;
    run_en_d    = run_en_q;
    if (clr_pulse_d) begin
      run_en_d = 1'b0;
    end else if (run_pulse_d) begin
      run_en_d = ~run_en_q;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      run_pulse_q <= 1'b0;
      clr_pulse_q <= 1'b0;
      run_en_q    <= 1'b0;
    end else begin
      run_pulse_q <= run_pulse_d;
      clr_pulse_q <= clr_pulse_d;
      run_en_q    <= run_en_d;
    end
  end

  assign btn_if.run_en     = run_en_q;
  assign btn_if.run_pulse  = run_pulse_q;
  assign btn_if.clr_pulse  = clr_pulse_q;
  assign btn_if.btn_run_db = btn_db[RUN_IDX];
  assign btn_if.btn_clr_db = btn_db[CLR_IDX];

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Purpose: directed self-checking bench for button_conditioner with
// DEBOUNCE_COUNT=4 and LONG_COUNT=20. Inputs change 1 ns after a rising
// edge ("after edge N"); outputs are sampled at the same point, so a raw
// level set after edge 0 is seen debounced after edge 6 and pulsed after
// edge 7. Long-press expectations follow BUTTON_CONDITIONER_LONG_PRESS_EN.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk_in;
  logic reset;
  int   total;
  int   bad;

  button_conditioner_if bc_if ();

  button_conditioner #(
    .DEBOUNCE_COUNT (4),
    .LONG_COUNT     (20)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .btn_if (bc_if)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bc_if.btn_run = 1'b0;
    bc_if.btn_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bc_if.btn_run = 1'b0;
    bc_if.btn_clr = 1'b0;
    #2;
    total++; if (bc_if.run_en !== 1'b0) begin bad++; $display("FAIL reset_run_en: got %b need 0", bc_if.run_en); end
    total++; if (bc_if.run_pulse !== 1'b0) begin bad++; $display("FAIL reset_run_pulse: got %b need 0", bc_if.run_pulse); end
    total++; if (bc_if.clr_pulse !== 1'b0) begin bad++; $display("FAIL reset_clr_pulse: got %b need 0", bc_if.clr_pulse); end
    total++; if (bc_if.btn_run_db !== 1'b0) begin bad++; $display("FAIL reset_run_db: got %b need 0", bc_if.btn_run_db); end
    total++; if (bc_if.btn_clr_db !== 1'b0) begin bad++; $display("FAIL reset_clr_db: got %b need 0", bc_if.btn_clr_db); end
    tick();
    tick();
    reset = 1'b0;
    repeat (8) tick();
    total++; if (bc_if.run_en !== 1'b0) begin bad++; $display("FAIL idle_run_en: got %b need 0", bc_if.run_en); end
    total++; if (bc_if.btn_run_db !== 1'b0) begin bad++; $display("FAIL idle_run_db: got %b need 0", bc_if.btn_run_db); end
    $display("test_reset: done");
  endtask

  task automatic test_clean_press();
    do_reset();
    bc_if.btn_run = 1'b1;                // after edge 0
    repeat (5) tick();                   // after edge 5
    total++; if (bc_if.btn_run_db !== 1'b0) begin bad++; $display("FAIL press_db_e5: got %b need 0", bc_if.btn_run_db); end
    tick();                              // after edge 6
    total++; if (bc_if.btn_run_db !== 1'b1) begin bad++; $display("FAIL press_db_e6: got %b need 1", bc_if.btn_run_db); end
    total++; if (bc_if.run_pulse !== 1'b0) begin bad++; $display("FAIL press_pulse_e6: got %b need 0", bc_if.run_pulse); end
    total++; if (bc_if.run_en !== 1'b0) begin bad++; $display("FAIL press_run_en_e6: got %b need 0", bc_if.run_en); end
    tick();                              // after edge 7
    total++; if (bc_if.run_pulse !== 1'b1) begin bad++; $display("FAIL press_pulse_e7: got %b need 1", bc_if.run_pulse); end
    total++; if (bc_if.run_en !== 1'b1) begin bad++; $display("FAIL press_run_en_e7: got %b need 1", bc_if.run_en); end
    tick();                              // after edge 8
    total++; if (bc_if.run_pulse !== 1'b0) begin bad++; $display("FAIL press_pulse_e8: got %b need 0", bc_if.run_pulse); end
    total++; if (bc_if.run_en !== 1'b1) begin bad++; $display("FAIL press_run_en_e8: got %b need 1", bc_if.run_en); end
    bc_if.btn_run = 1'b0;
    repeat (8) tick();
    total++; if (bc_if.btn_run_db !== 1'b0) begin bad++; $display("FAIL press_db_release: got %b need 0", bc_if.btn_run_db); end
    total++; if (bc_if.run_en !== 1'b1) begin bad++; $display("FAIL press_run_en_release: got %b need 1", bc_if.run_en); end
    $display("test_clean_press: done");
  endtask

  task automatic test_glitch();
    int db_seen;
    int pulse_seen;
    do_reset();
    db_seen    = 0;
    pulse_seen = 0;
    bc_if.btn_run = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (t == 3) bc_if.btn_run = 1'b0;
      if (bc_if.btn_run_db === 1'b1) db_seen++;
      if (bc_if.run_pulse === 1'b1) pulse_seen++;
    end
    total++; if (db_seen !== 0) begin bad++; $display("FAIL glitch_db_cycles: got %0d need 0", db_seen); end
    total++; if (pulse_seen !== 0) begin bad++; $display("FAIL glitch_pulses: got %0d need 0", pulse_seen); end
    total++; if (bc_if.run_en !== 1'b0) begin bad++; $display("FAIL glitch_run_en: got %b need 0", bc_if.run_en); end
    $display("test_glitch: done");
  endtask

  task automatic test_toggle_hold();
    int   press_pulses;
    int   release_pulses;
    logic en_after_first;
    press_pulses   = 0;
    release_pulses = 0;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      bc_if.btn_run = 1'b1;
      repeat (30) begin
        tick();
        if (bc_if.run_pulse === 1'b1) press_pulses++;
      end
      bc_if.btn_run = 1'b0;
      repeat (15) begin
        tick();
        if (bc_if.run_pulse === 1'b1) release_pulses++;
      end
      if (p == 0) en_after_first = bc_if.run_en;
    end
    // A 30-cycle hold passes the 20-cycle long press when it is built in.
    total++; if (en_after_first !== (LONG_EN ? 1'b0 : 1'b1)) begin bad++; $display("FAIL toggle_first_run_en: got %b need %b", en_after_first, LONG_EN ? 1'b0 : 1'b1); end
    total++; if (bc_if.run_en !== 1'b0) begin bad++; $display("FAIL toggle_second_run_en: got %b need 0", bc_if.run_en); end
    total++; if (press_pulses !== 2) begin bad++; $display("FAIL toggle_press_pulses: got %0d need 2", press_pulses); end
    total++; if (release_pulses !== 0) begin bad++; $display("FAIL toggle_release_pulses: got %0d need 0", release_pulses); end
    $display("test_toggle_hold: done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    bc_if.btn_run = 1'b1;
    bc_if.btn_clr = 1'b1;
    repeat (7) tick();
    total++; if (bc_if.run_pulse !== 1'b1) begin bad++; $display("FAIL simul_run_pulse: got %b need 1", bc_if.run_pulse); end
    total++; if (bc_if.clr_pulse !== 1'b1) begin bad++; $display("FAIL simul_clr_pulse: got %b need 1", bc_if.clr_pulse); end
    total++; if (bc_if.run_en !== 1'b0) begin bad++; $display("FAIL simul_run_en: got %b need 0", bc_if.run_en); end
    total++; if (bc_if.btn_clr_db !== 1'b1) begin bad++; $display("FAIL simul_clr_db: got %b need 1", bc_if.btn_clr_db); end
    tick();
    total++; if (bc_if.clr_pulse !== 1'b0) begin bad++; $display("FAIL simul_clr_pulse_next: got %b need 0", bc_if.clr_pulse); end
    total++; if (bc_if.run_en !== 1'b0) begin bad++; $display("FAIL simul_run_en_next: got %b need 0", bc_if.run_en); end
    bc_if.btn_run = 1'b0;
    bc_if.btn_clr = 1'b0;
    repeat (8) tick();
    $display("test_simultaneous: done");
  endtask

  task automatic test_reset_mid_press();
    int pulses;
    int pulse_tick;
    pulses     = 0;
    pulse_tick = -1;
    do_reset();
    bc_if.btn_run = 1'b1;
    repeat (10) tick();
    total++; if (bc_if.btn_run_db !== 1'b1) begin bad++; $display("FAIL midrst_pre_db: got %b need 1", bc_if.btn_run_db); end
    total++; if (bc_if.run_en !== 1'b1) begin bad++; $display("FAIL midrst_pre_run_en: got %b need 1", bc_if.run_en); end
    reset = 1'b1;
    #1;
    total++; if (bc_if.run_en !== 1'b0) begin bad++; $display("FAIL midrst_run_en: got %b need 0", bc_if.run_en); end
    total++; if (bc_if.btn_run_db !== 1'b0) begin bad++; $display("FAIL midrst_db: got %b need 0", bc_if.btn_run_db); end
    tick();
    tick();
    reset = 1'b0;                        // released after edge R0
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (bc_if.run_pulse === 1'b1) begin
        pulses++;
        if (pulse_tick < 0) pulse_tick = t;
      end
    end
    // Same latency as a fresh press: debounced after R6, pulse after R7.
    total++; if (pulses !== 1) begin bad++; $display("FAIL midrst_pulse_count: got %0d need 1", pulses); end
    total++; if (pulse_tick !== 7) begin bad++; $display("FAIL midrst_pulse_tick: got %0d need 7", pulse_tick); end
    total++; if (bc_if.run_en !== 1'b1) begin bad++; $display("FAIL midrst_run_en_after: got %b need 1", bc_if.run_en); end
    bc_if.btn_run = 1'b0;
    repeat (8) tick();
    $display("test_reset_mid_press: done");
  endtask

  task automatic test_long_press();
    int run_pulses;
    int run_tick;
    int clr_pulses;
    int clr_tick;
    run_pulses = 0;
    clr_pulses = 0;
    run_tick   = -1;
    clr_tick   = -1;
    do_reset();
    bc_if.btn_run = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (bc_if.run_pulse === 1'b1) begin
        run_pulses++;
        if (run_tick < 0) run_tick = t;
      end
      if (bc_if.clr_pulse === 1'b1) begin
        clr_pulses++;
        if (clr_tick < 0) clr_tick = t;
      end
    end
    bc_if.btn_run = 1'b0;
    repeat (10) tick();
    total++; if (run_pulses !== 1) begin bad++; $display("FAIL long_run_pulses: got %0d need 1", run_pulses); end
    total++; if (run_tick !== 7) begin bad++; $display("FAIL long_run_tick: got %0d need 7", run_tick); end
    if (LONG_EN) begin
      // Clear lands 20 cycles after the run pulse cycle.
      total++; if (clr_pulses !== 1) begin bad++; $display("FAIL long_clr_pulses: got %0d need 1", clr_pulses); end
      total++; if (clr_tick !== 27) begin bad++; $display("FAIL long_clr_tick: got %0d need 27", clr_tick); end
      total++; if (bc_if.run_en !== 1'b0) begin bad++; $display("FAIL long_run_en: got %b need 0", bc_if.run_en); end
    end else begin
      total++; if (clr_pulses !== 0) begin bad++; $display("FAIL long_clr_pulses: got %0d need 0", clr_pulses); end
      total++; if (bc_if.run_en !== 1'b1) begin bad++; $display("FAIL long_run_en: got %b need 1", bc_if.run_en); end
    end
    $display("test_long_press: done");
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    bc_if.btn_run = 1'b0;
    bc_if.btn_clr = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_toggle_hold();
    test_simultaneous();
    test_reset_mid_press();
    test_long_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
